// File: rtl/cache_fill_ctrl.sv
// Miss-handling fill controller for the 4-way cache data array.
// Issues eight pipelined word reads and writes each returned word into the victim way.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [3:0]        victim_way,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic [ADDR_W-1:0] memory_address,
    output logic              memory_read_en,
    output logic [DATA_W-1:0] fill_data,
    output logic [3:0]        fill_write,
    output logic [31:0]       fill_block_en,
    output logic [WORDS-1:0]  fill_word_en,
    output logic              tag_write,
    output logic              fsm_busy,
    output logic              fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        issue_cnt_r;
    logic [2:0]        recv_cnt_r;
    logic [ADDR_W-1:0] base_r;
    logic [4:0]        set_r;
    logic [3:0]        way_r;
    logic              accept_s;
    logic              issue_s;
    logic              write_s;

    // A malformed LRU choice collapses to its lowest set bit, or way 0 when empty.
    function automatic logic [3:0] onehot_way(input logic [3:0] way);
        logic [3:0] lowest;
        lowest = way & (~way + 4'd1);
        if (way == 4'd0) begin
            return 4'b0001;
        end else begin
            return lowest;
        end
    endfunction

    // State register, request/return counters and the fields latched at miss acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            issue_cnt_r <= 4'd0;
            recv_cnt_r  <= 3'd0;
            base_r      <= {ADDR_W{1'b0}};
            set_r       <= 5'd0;
            way_r       <= 4'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                base_r      <= miss_address & ~ADDR_W'(4'hF);
                set_r       <= miss_address[8:4];
                way_r       <= onehot_way(victim_way);
                issue_cnt_r <= 4'd0;
                recv_cnt_r  <= 3'd0;
            end else begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r + 4'd1;
                end
                if (write_s) begin
                    recv_cnt_r <= recv_cnt_r + 3'd1;
                end
            end
        end
    end

    // Next-state decode plus the issue and receive sides, which run independently in FILL
    always_comb begin
        state_next_s   = state_r;
        accept_s       = 1'b0;
        issue_s        = 1'b0;
        write_s        = 1'b0;
        memory_read_en = 1'b0;
        memory_address = {ADDR_W{1'b0}};
        fill_data      = {DATA_W{1'b0}};
        fill_write     = 4'd0;
        fill_block_en  = 32'd0;
        fill_word_en   = {WORDS{1'b0}};
        tag_write      = 1'b0;
        fill_done      = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_detected) begin
                    accept_s     = 1'b1;
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (issue_cnt_r < 4'(WORDS)) begin
                    issue_s        = 1'b1;
                    memory_read_en = 1'b1;
                    memory_address = base_r + ADDR_W'({issue_cnt_r[2:0], 1'b0});
                end else begin
                    issue_s = 1'b0;
                end
                if (memory_data_valid) begin
                    write_s       = 1'b1;
                    fill_data     = memory_data;
                    fill_write    = way_r;
                    fill_block_en = 32'd1 << set_r;
                    fill_word_en  = {{(WORDS-1){1'b0}}, 1'b1} << recv_cnt_r;
                    if (recv_cnt_r == 3'(WORDS - 1)) begin
                        tag_write    = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = FILL;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            DONE: begin
                fill_done    = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign fsm_busy = (state_r != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl with a transaction-level reference model.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [3:0]  victim_way;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic [15:0] memory_address;
    logic        memory_read_en;
    logic [15:0] fill_data;
    logic [3:0]  fill_write;
    logic [31:0] fill_block_en;
    logic [7:0]  fill_word_en;
    logic        tag_write;
    logic        fsm_busy;
    logic        fill_done;

    cache_fill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .victim_way       (victim_way),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .memory_address   (memory_address),
        .memory_read_en   (memory_read_en),
        .fill_data        (fill_data),
        .fill_write       (fill_write),
        .fill_block_en    (fill_block_en),
        .fill_word_en     (fill_word_en),
        .tag_write        (tag_write),
        .fsm_busy         (fsm_busy),
        .fill_done        (fill_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a fill in progress, the block it targets and the reads still owed
    bit          m_fill = 1'b0;
    bit          m_done = 1'b0;
    int          m_words = 0;
    int          m_set = 0;
    logic [3:0]  m_way = 4'd0;
    logic [15:0] req_q[$];
    bit          exp_done_s = 1'b0;
    bit          obs_done = 1'b0;
    bit          obs_tag = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick_way(input logic [3:0] w);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) return 4'(1 << b);
        end
        return 4'b0001;
    endfunction

    // One clock cycle: predict, compare mid-cycle, advance the model across the edge
    task automatic step();
        logic        e_rd, e_tag, e_busy, e_done;
        logic [15:0] e_addr, e_data;
        logic [3:0]  e_way;
        logic [31:0] e_be;
        logic [7:0]  e_we;
        e_rd = 0; e_tag = 0; e_busy = 0; e_done = 0;
        e_addr = 0; e_data = 0; e_way = 0; e_be = 0; e_we = 0;
        if (m_fill) begin
            e_busy = 1;
            if (req_q.size() > 0) begin
                e_rd   = 1;
                e_addr = req_q[0];
            end
            if (memory_data_valid) begin
                e_data = memory_data;
                e_way  = m_way;
                e_be   = 32'd1 << m_set;
                e_we   = 8'd1 << m_words;
                e_tag  = (m_words == 7);
            end
        end else if (m_done) begin
            e_busy = 1;
            e_done = 1;
        end
        @(negedge clk);
        check_eq("rd_en", memory_read_en, e_rd);
        check_eq("rd_addr", memory_address, e_addr);
        check_eq("fill_data", fill_data, e_data);
        check_eq("fill_write", fill_write, e_way);
        check_eq("block_en", fill_block_en, e_be);
        check_eq("word_en", fill_word_en, e_we);
        check_eq("tag_write", tag_write, e_tag);
        check_eq("busy", fsm_busy, e_busy);
        check_eq("done", fill_done, e_done);
        obs_done   = fill_done;
        obs_tag    = tag_write;
        exp_done_s = e_done;
        if (rst) begin
            m_fill = 0; m_done = 0; m_words = 0;
            req_q.delete();
        end else if (m_fill) begin
            if (req_q.size() > 0) void'(req_q.pop_front());
            if (memory_data_valid) begin
                m_words++;
                if (m_words == 8) begin
                    m_fill = 0;
                    m_done = 1;
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (miss_detected) begin
            m_fill  = 1;
            m_words = 0;
            m_set   = (miss_address / 16) % 32;
            m_way   = pick_way(victim_way);
            req_q.delete();
            for (int i = 0; i < 8; i++) req_q.push_back(16'((miss_address / 16) * 16 + 2 * i));
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: each word returns 4 cycles after its request plus a stray 9th valid; mode 1: random gaps
    task automatic run_fill(input logic [15:0] addr, input logic [3:0] way, input int mode,
                            input int rst_after, input bit stray_miss);
        int given, gap, tags, dones, done_cyc, issued;
        bit v, finished;
        given = 0; tags = 0; dones = 0; done_cyc = -1; finished = 0;
        gap = $urandom_range(0, 3);
        miss_detected = 1; miss_address = addr; victim_way = way;
        memory_data_valid = 0; memory_data = 16'($urandom);
        step();
        for (int c = 1; c < 100; c++) begin
            miss_address  = 16'($urandom);
            victim_way    = 4'($urandom);
            memory_data   = 16'($urandom);
            miss_detected = stray_miss && (c >= 2) && (c <= 4);
            if (miss_detected) miss_address = 16'h4000;
            issued = (c - 1 < 8) ? c - 1 : 8;
            v = 0;
            if (mode == 0) begin
                v = (c >= 5) && (c <= 13);
            end else if (given < issued) begin
                if (gap == 0) begin
                    v   = 1;
                    gap = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            if (rst_after >= 0 && given == rst_after) begin
                v   = 0;
                rst = 1;
            end
            memory_data_valid = v;
            step();
            if (v) given++;
            tags  += int'(obs_tag);
            dones += int'(obs_done);
            if (obs_done) done_cyc = c;
            if (rst) begin
                rst = 0;
                finished = 1;
                break;
            end
            if (exp_done_s) begin
                finished = 1;
                break;
            end
        end
        check_eq("fill_end", finished, 1);
        miss_detected = 0;
        memory_data_valid = 1;
        step();
        memory_data_valid = 0;
        step();
        check_eq("tag_cnt", tags, (rst_after >= 0) ? 0 : 1);
        check_eq("done_cnt", dones, (rst_after >= 0) ? 0 : 1);
        if (mode == 0 && rst_after < 0) check_eq("done_lat", done_cyc, 13);
    endtask

    initial begin
        rst = 1; miss_detected = 0; miss_address = 0; victim_way = 0;
        memory_data = 0; memory_data_valid = 0;
        @(posedge clk);
        #1;
        step();
        memory_data_valid = 1;
        step();
        rst = 0;
        memory_data_valid = 0;
        step();
        run_fill(16'h1A36, 4'b0100, 0, -1, 0);
        for (int k = 0; k < 4; k++) run_fill(16'($urandom), 4'($urandom), 1, -1, k[0]);
        run_fill(16'($urandom), 4'b1010, 1, -1, 1);
        run_fill(16'($urandom), 4'b0000, 1, -1, 0);
        run_fill(16'h2345, 4'b1000, 0, 3, 0);
        run_fill(16'h0010, 4'b0001, 1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
